// File: rtl/thermo_sense_frontend.sv
// Thermostat sensor front end: hysteresis compare, debounce and stale-sample fault detection.
// Define THERMO_AVG_EN to compare a 4-sample running average instead of the raw sample.
module thermo_sense_frontend #(
    parameter int unsigned TEMP_W   = 8,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp_data,
    input  logic [TEMP_W-1:0] setpoint,
    input  logic [TEMP_W-1:0] hyst,
    output logic              too_cold,
    output logic              too_hot,
    output logic              sensor_fault,
    output logic [1:0]        state
);

    localparam int unsigned EXT_W = TEMP_W + 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_COLD   = 2'd1,
        ST_HOT    = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            db_tgt_q;
    state_t            qual_tgt_c;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_nxt_c;
    logic [TO_W-1:0]   to_cnt_q;
    logic [TEMP_W-1:0] cmp_temp_c;
    logic              cmp_ok_c;
    logic [EXT_W-1:0]  sp_ext_c;
    logic [EXT_W-1:0]  hy_ext_c;
    logic [EXT_W-1:0]  t_ext_c;
    logic [EXT_W-1:0]  lo_thr_c;
    logic [EXT_W-1:0]  hi_thr_c;
    logic              cold_q_c;
    logic              hot_q_c;
    logic              qual_c;
    logic              timeout_c;

    assign timeout_c = !temp_valid && (state_q != ST_FAULT)
                       && (to_cnt_q == TO_W'(TIMEOUT - 1));

`ifdef THERMO_AVG_EN
    localparam int unsigned SUM_W = TEMP_W + 2;

    logic [2:0][TEMP_W-1:0] hist_q;
    logic [1:0]             hist_cnt_q;
    logic [SUM_W-1:0]       avg_sum_c;

    assign avg_sum_c  = SUM_W'(temp_data) + SUM_W'(hist_q[0])
                      + SUM_W'(hist_q[1]) + SUM_W'(hist_q[2]);
    assign cmp_temp_c = avg_sum_c[SUM_W-1:2];
    assign cmp_ok_c   = (hist_cnt_q == 2'd3);

    // History of accepted samples; wiped on reset and when the sensor is declared dead
    always_ff @(posedge clk) begin
        if (rst || timeout_c) begin
            hist_q     <= '0;
            hist_cnt_q <= 2'd0;
        end else if (temp_valid) begin
            hist_q[2] <= hist_q[1];
            hist_q[1] <= hist_q[0];
            hist_q[0] <= temp_data;
            if (hist_cnt_q != 2'd3) begin
                hist_cnt_q <= hist_cnt_q + 2'd1;
            end
        end
    end
`else
    assign cmp_temp_c = temp_data;
    assign cmp_ok_c   = 1'b1;
`endif

    // Thresholds in one extra bit so setpoint+hyst keeps its carry
    assign sp_ext_c = EXT_W'(setpoint);
    assign hy_ext_c = EXT_W'(hyst);
    assign t_ext_c  = EXT_W'(cmp_temp_c);
    assign lo_thr_c = sp_ext_c - hy_ext_c;
    assign hi_thr_c = sp_ext_c + hy_ext_c;
    assign cold_q_c = (hyst <= setpoint) && (t_ext_c < lo_thr_c);
    assign hot_q_c  = (t_ext_c > hi_thr_c);

    always_comb begin
        qual_c     = 1'b0;
        qual_tgt_c = ST_NORMAL;
        case (state_q)
            ST_NORMAL: begin
                if (cold_q_c) begin
                    qual_c     = 1'b1;
                    qual_tgt_c = ST_COLD;
                end else if (hot_q_c) begin
                    qual_c     = 1'b1;
                    qual_tgt_c = ST_HOT;
                end
            end
            ST_COLD:  qual_c = (cmp_temp_c >= setpoint);
            ST_HOT:   qual_c = (cmp_temp_c <= setpoint);
            default:  qual_c = 1'b0;
        endcase
        if (!cmp_ok_c) begin
            qual_c = 1'b0;
        end
    end

    // A run continues only while the target is unchanged; otherwise it restarts at one
    assign db_cnt_nxt_c = ((db_cnt_q != '0) && (db_tgt_q == qual_tgt_c))
                          ? db_cnt_q + DB_W'(1) : DB_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            db_tgt_q     <= ST_NORMAL;
            db_cnt_q     <= '0;
            to_cnt_q     <= '0;
            too_cold     <= 1'b0;
            too_hot      <= 1'b0;
            sensor_fault <= 1'b0;
        end else if (!temp_valid) begin
            if (timeout_c) begin
                state_q      <= ST_FAULT;
                db_cnt_q     <= '0;
                to_cnt_q     <= '0;
                too_cold     <= 1'b0;
                too_hot      <= 1'b0;
                sensor_fault <= 1'b1;
            end else if (state_q != ST_FAULT) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_q <= '0;
            if (state_q == ST_FAULT) begin
                // Recovery sample only revives the sensor; it does not count toward a change
                state_q      <= ST_NORMAL;
                db_cnt_q     <= '0;
                sensor_fault <= 1'b0;
            end else if (qual_c) begin
                if (db_cnt_nxt_c == DB_W'(DEBOUNCE)) begin
                    state_q  <= qual_tgt_c;
                    db_cnt_q <= '0;
                    too_cold <= (qual_tgt_c == ST_COLD);
                    too_hot  <= (qual_tgt_c == ST_HOT);
                end else begin
                    db_cnt_q <= db_cnt_nxt_c;
                    db_tgt_q <= qual_tgt_c;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_thermo_sense_frontend.sv
// Directed bench for thermo_sense_frontend: stimulus queues expected outputs, a monitor compares them.
module tb_thermo_sense_frontend;

    localparam int unsigned TEMP_W = 8;

    localparam logic [4:0] E_NORM  = 5'b00_000;
    localparam logic [4:0] E_COLD  = 5'b01_100;
    localparam logic [4:0] E_HOT   = 5'b10_010;
    localparam logic [4:0] E_FAULT = 5'b11_001;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              temp_valid = 1'b0;
    logic [TEMP_W-1:0] temp_data = '0;
    logic [TEMP_W-1:0] setpoint = '0;
    logic [TEMP_W-1:0] hyst = '0;
    logic              too_cold;
    logic              too_hot;
    logic              sensor_fault;
    logic [1:0]        state;

    typedef struct {
        string      name;
        int         due;
        logic [4:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    thermo_sense_frontend #(
        .TEMP_W  (TEMP_W),
        .DEBOUNCE(3),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .temp_valid  (temp_valid),
        .temp_data   (temp_data),
        .setpoint    (setpoint),
        .hyst        (hyst),
        .too_cold    (too_cold),
        .too_hot     (too_hot),
        .sensor_fault(sensor_fault),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation whose cycle has arrived
    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] act;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e   = q.pop_front();
            act = {state, too_cold, too_hot, sensor_fault};
            checks++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL %s: got state/cold/hot/fault=%b required %b", e.name, act, e.exp);
            end
        end
    end

    task automatic tick(input logic v, input logic [TEMP_W-1:0] t);
        temp_valid = v;
        temp_data  = t;
        @(posedge clk);
        #1;
        temp_valid = 1'b0;
    endtask

    // One valid sample followed by one idle cycle
    task automatic sample(input logic [TEMP_W-1:0] t);
        tick(1'b1, t);
        tick(1'b0, '0);
    endtask

    task automatic expect_out(input string name, input logic [4:0] e);
        exp_t x;
        x.name = name;
        x.due  = cyc;
        x.exp  = e;
        q.push_back(x);
    endtask

    initial begin
        #1;
        rst = 1'b1;
        tick(1'b0, '0);
        tick(1'b0, '0);
        expect_out("reset", E_NORM);
        rst = 1'b0;

        setpoint = 8'd25;
        hyst     = 8'd2;
        sample(8'd20); sample(8'd20); sample(8'd24);
        expect_out("broken_run", E_NORM);
        sample(8'd20); sample(8'd20);
        expect_out("restart_2of3", E_NORM);
        tick(1'b1, 8'd20);
        expect_out("cold_enter", E_COLD);
        tick(1'b0, '0);

        sample(8'd24); sample(8'd24);
        expect_out("cold_hold_24", E_COLD);
        sample(8'd25); sample(8'd25);
        expect_out("cold_2of3_exit", E_COLD);
        tick(1'b1, 8'd25);
        expect_out("cold_exit", E_NORM);
        tick(1'b0, '0);

        sample(8'd28); sample(8'd28);
        expect_out("hot_2of3", E_NORM);
        tick(1'b1, 8'd28);
        expect_out("hot_enter", E_HOT);
        tick(1'b0, '0);
        sample(8'd27);
        expect_out("hot_hold_27", E_HOT);
        sample(8'd25); sample(8'd25);
        expect_out("hot_2of3_exit", E_HOT);
        tick(1'b1, 8'd25);
        expect_out("hot_exit", E_NORM);
        tick(1'b0, '0);

        setpoint = 8'd1;
        hyst     = 8'd2;
        sample(8'd0); sample(8'd0); sample(8'd0);
        expect_out("hyst_gt_setpoint", E_NORM);

        setpoint = 8'd250;
        hyst     = 8'd10;
        sample(8'd255); sample(8'd255); sample(8'd255);
        expect_out("hot_carry", E_NORM);

        setpoint = 8'd25;
        hyst     = 8'd2;
        sample(8'd20); sample(8'd20);
        rst = 1'b1;
        tick(1'b0, '0);
        rst = 1'b0;
        expect_out("mid_run_reset", E_NORM);
        sample(8'd20);
        expect_out("post_reset_1", E_NORM);
        sample(8'd20);
        expect_out("post_reset_2", E_NORM);
        tick(1'b1, 8'd20);
        expect_out("post_reset_3", E_COLD);

        for (int i = 0; i < 15; i++) tick(1'b0, '0);
        expect_out("idle_15", E_COLD);
        tick(1'b0, '0);
        expect_out("timeout_fault", E_FAULT);
        tick(1'b0, '0); tick(1'b0, '0);
        expect_out("fault_hold", E_FAULT);
        tick(1'b1, 8'd20);
        expect_out("fault_exit", E_NORM);
        tick(1'b0, '0);
        sample(8'd20); sample(8'd20);
        expect_out("after_fault_2", E_NORM);
        tick(1'b1, 8'd20);
        expect_out("after_fault_cold", E_COLD);
        tick(1'b0, '0);

        sample(8'd30); sample(8'd30);
        expect_out("cold_to_norm_2", E_COLD);
        tick(1'b1, 8'd30);
        expect_out("cold_to_norm", E_NORM);
        tick(1'b0, '0);
        sample(8'd30); sample(8'd30);
        expect_out("no_direct_hot", E_NORM);
        tick(1'b1, 8'd30);
        expect_out("norm_to_hot", E_HOT);
        tick(1'b0, '0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked expectations required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
